// File: rtl/axi_decerr_slave.sv
// ============================================================================
// Module      : axi_decerr_slave
// Description : AXI default slave. Accepts unmapped requests, drains write
//               data, and answers every transaction with DECERR (2'b11).
//               Optional fault-address capture under AXI_DECERR_CAPTURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_decerr_slave #(
    parameter int                    ID_WIDTH   = 6,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESP_DATA  = DATA_WIDTH'(64'hBADC_AB1E)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [63:0]           aw_addr_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic                  w_last_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [63:0]           ar_addr_i,
    input  logic [7:0]            ar_len_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic                  fault_valid_o,
    output logic [63:0]           fault_addr_o,
    input  logic                  fault_clr_i
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    localparam logic [1:0] C_DECERR = 2'b11;

    wstate_t    wstate;
    rstate_t    rstate;
    logic [7:0] rcnt;

    assign b_resp_o = C_DECERR;
    assign r_resp_o = C_DECERR;
    assign r_data_o = RESP_DATA;

    // Ready comes up one cycle after reset release since it is registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate     <= W_IDLE;
            aw_ready_o <= 1'b0;
            w_ready_o  <= 1'b0;
            b_valid_o  <= 1'b0;
            b_id_o     <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    aw_ready_o <= 1'b1;
                    if (aw_valid_i && aw_ready_o) begin
                        b_id_o     <= aw_id_i;
                        aw_ready_o <= 1'b0;
                        w_ready_o  <= 1'b1;
                        wstate     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_valid_i && w_ready_o && w_last_i) begin
                        w_ready_o <= 1'b0;
                        b_valid_o <= 1'b1;
                        wstate    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_o  <= 1'b0;
                        aw_ready_o <= 1'b1;
                        wstate     <= W_IDLE;
                    end
                end
                default: begin
                    aw_ready_o <= 1'b0;
                    w_ready_o  <= 1'b0;
                    b_valid_o  <= 1'b0;
                    wstate     <= W_IDLE;
                end
            endcase
        end
    end

    // rcnt holds beats remaining after the one currently presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstate     <= R_IDLE;
            ar_ready_o <= 1'b0;
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_id_o     <= '0;
            rcnt       <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    ar_ready_o <= 1'b1;
                    if (ar_valid_i && ar_ready_o) begin
                        r_id_o     <= ar_id_i;
                        rcnt       <= ar_len_i;
                        r_last_o   <= (ar_len_i == 8'd0);
                        r_valid_o  <= 1'b1;
                        ar_ready_o <= 1'b0;
                        rstate     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        if (rcnt == 8'd0) begin
                            r_valid_o  <= 1'b0;
                            r_last_o   <= 1'b0;
                            ar_ready_o <= 1'b1;
                            rstate     <= R_IDLE;
                        end else begin
                            rcnt     <= rcnt - 8'd1;
                            r_last_o <= (rcnt == 8'd1);
                        end
                    end
                end
                default: begin
                    ar_ready_o <= 1'b0;
                    r_valid_o  <= 1'b0;
                    r_last_o   <= 1'b0;
                    rstate     <= R_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_DECERR_CAPTURE_EN
    logic        aw_hs;
    logic        ar_hs;
    logic        fault_valid_q;
    logic [63:0] fault_addr_q;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;

    // A capture can only happen while clear, so it naturally wins over fault_clr_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if (!fault_valid_q && (aw_hs || ar_hs)) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= aw_hs ? aw_addr_i : ar_addr_i;
        end else if (fault_clr_i) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign fault_valid_o = fault_valid_q;
    assign fault_addr_o  = fault_addr_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{fault_clr_i, aw_addr_i, ar_addr_i};
    assign fault_valid_o = 1'b0;
    assign fault_addr_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_decerr_slave.sv
// Randomized + directed bench for axi_decerr_slave; a transaction-level model
// predicts every output and a negedge process compares each cycle.
`default_nettype none

module tb_axi_decerr_slave;

    localparam logic [63:0] RESP = 64'hBADC_AB1E;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [5:0]  aw_id, b_id, ar_id, r_id;
    logic [63:0] aw_addr, ar_addr, r_data, fault_addr;
    logic [1:0]  b_resp, r_resp;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [7:0]  ar_len;
    logic        fault_valid, fault_clr;

    int errors = 0;
    int checks = 0;

    axi_decerr_slave dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .fault_valid_o(fault_valid), .fault_addr_o(fault_addr), .fault_clr_i(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: write phase 0=idle 1=data 2=resp; read phase 0=idle 1=burst.
    int          wph, rph, m_len, m_beat;
    logic [5:0]  m_bid, m_rid;
    bit          fresh;
    logic        m_fv;
    logic [63:0] m_fa;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wph <= 0; rph <= 0; fresh <= 1'b1; m_fv <= 1'b0; m_fa <= '0;
            m_len <= 0; m_beat <= 0; m_bid <= '0; m_rid <= '0;
        end else begin
`ifdef AXI_DECERR_CAPTURE_EN
            if (!m_fv && !fresh && ((aw_valid && wph == 0) || (ar_valid && rph == 0))) begin
                m_fv <= 1'b1;
                m_fa <= (aw_valid && wph == 0) ? aw_addr : ar_addr;
            end else if (fault_clr) begin
                m_fv <= 1'b0;
            end
`endif
            if (wph == 0 && aw_valid && !fresh) begin
                wph <= 1; m_bid <= aw_id;
            end else if (wph == 1 && w_valid && w_last) begin
                wph <= 2;
            end else if (wph == 2 && b_ready) begin
                wph <= 0;
            end
            if (rph == 0 && ar_valid && !fresh) begin
                rph <= 1; m_rid <= ar_id; m_len <= int'(ar_len); m_beat <= 0;
            end else if (rph == 1 && r_ready) begin
                if (m_beat == m_len) rph <= 0;
                else m_beat <= m_beat + 1;
            end
            fresh <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("aw_ready", aw_ready, (wph == 0 && !fresh));
        check("w_ready", w_ready, wph == 1);
        check("b_valid", b_valid, wph == 2);
        check("ar_ready", ar_ready, (rph == 0 && !fresh));
        check("r_valid", r_valid, rph == 1);
        check("b_resp", b_resp, 2'b11);
        check("r_resp", r_resp, 2'b11);
        check("r_data", r_data, RESP);
        check("fault_valid", fault_valid, m_fv);
        check("fault_addr", fault_addr, m_fa);
        if (wph == 2) check("b_id", b_id, m_bid);
        if (rph == 1) begin
            check("r_id", r_id, m_rid);
            check("r_last", r_last, m_beat == m_len);
        end
    end

    logic [5:0] last_b_id, last_r_id;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // ch: 0=AW 1=W 2=AR 3=B (b_ready must already be high)
    task automatic wait_hs(input int ch, input string nm);
        int n = 0;
        bit hs = 0;
        while (!hs && n < 400) begin
            @(posedge clk);
            case (ch)
                0: hs = aw_ready;
                1: hs = w_ready;
                2: hs = ar_ready;
                default: begin hs = b_valid; last_b_id = b_id; end
            endcase
            n++;
            #1;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL timeout %s: no handshake after %0d cycles, required 1", nm, n);
        end
    endtask

    task automatic do_ar(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len;
        wait_hs(2, "ar");
        ar_valid = 0;
    endtask

    task automatic do_write(input logic [5:0] id, input logic [63:0] addr);
        aw_valid = 1; aw_id = id; aw_addr = addr;
        wait_hs(0, "aw");
        aw_valid = 0; w_valid = 1; w_last = 1;
        wait_hs(1, "w");
        w_valid = 0; w_last = 0; b_ready = 1;
        wait_hs(3, "b");
        b_ready = 0;
    endtask

    task automatic collect(input int expn, input bit toggle, input string nm);
        int n = 0, lastn = 0, cyc_n = 0;
        bit done = 0;
        while (!done && cyc_n < 2000) begin
            @(posedge clk);
            if (r_valid && r_ready) begin
                n++;
                last_r_id = r_id;
                if (r_last) begin lastn++; done = 1; end
            end
            cyc_n++;
            #1;
            if (toggle) r_ready = $urandom_range(0, 1);
        end
        r_ready = 0;
        check({nm, "_beats"}, n, expn);
        check({nm, "_lastcnt"}, lastn, 1);
    endtask

    initial begin
        bit hsw, hsr;
        rst_n = 0;
        {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, fault_clr} = '0;
        aw_id = '0; ar_id = '0; aw_addr = '0; ar_addr = '0; ar_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", aw_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_ids", {b_id, r_id}, 12'h0);
        check("rst_r_data", r_data, 64'hBADC_AB1E);
        @(posedge clk); #1 rst_n = 1;
        cyc();
        check("post_rst_aw_ready", aw_ready, 1);

        // Single-beat write: B one cycle after the last W handshake
        aw_valid = 1; aw_id = 6'h05; aw_addr = 64'h1400_0000;
        wait_hs(0, "t1_aw");
        aw_valid = 0; w_valid = 1; w_last = 1;
        wait_hs(1, "t1_w");
        w_valid = 0; w_last = 0;
        check("t1_b_valid", b_valid, 1);
        check("t1_b_id", b_id, 6'h05);
        check("t1_b_resp", b_resp, 2'b11);
        b_ready = 1; wait_hs(3, "t1_b"); b_ready = 0;

        // 4-beat read with ready held high
        r_ready = 1;
        do_ar(6'h12, 64'h1500_0000, 8'd3);
        check("t2_r_latency", r_valid, 1);
        r_ready = 1;
        collect(4, 0, "t2");
        check("t2_r_id", last_r_id, 6'h12);

        // 256-beat read with random backpressure
        do_ar(6'h01, 64'h1600_0000, 8'hFF);
        collect(256, 1, "t3");

        // AW and AR accepted in the same cycle
        aw_valid = 1; aw_id = 6'h2A; aw_addr = 64'h1700_0000;
        ar_valid = 1; ar_id = 6'h15; ar_addr = 64'h1800_0000; ar_len = 8'd0;
        @(posedge clk); hsw = aw_ready; hsr = ar_ready; #1;
        aw_valid = 0; ar_valid = 0;
        check("t4_aw_acc", hsw, 1);
        check("t4_ar_acc", hsr, 1);
        w_valid = 1; w_last = 0; wait_hs(1, "t4_w0");
        w_last = 1; wait_hs(1, "t4_w1");
        w_valid = 0; w_last = 0;
        r_ready = 1;
        collect(1, 0, "t4_r");
        check("t4_r_id", last_r_id, 6'h15);
        b_ready = 1; wait_hs(3, "t4_b"); b_ready = 0;
        check("t4_b_id", last_b_id, 6'h2A);

        // Random traffic; the model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            aw_valid  = ($urandom % 3) == 0;
            aw_id     = 6'($urandom);
            aw_addr   = {$urandom, $urandom};
            w_valid   = $urandom_range(0, 1);
            w_last    = $urandom_range(0, 1);
            b_ready   = $urandom_range(0, 1);
            ar_valid  = ($urandom % 3) == 0;
            ar_id     = 6'($urandom);
            ar_addr   = {$urandom, $urandom};
            ar_len    = 8'($urandom_range(0, 5));
            r_ready   = $urandom_range(0, 1);
            fault_clr = ($urandom % 20) == 0;
            cyc();
        end
        {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, fault_clr} = '0;
        rst_n = 0; cyc(); cyc(); rst_n = 1; cyc();

        // Reset during the second beat of a 4-beat read
        r_ready = 1;
        do_ar(6'h21, 64'h1900_0000, 8'd3);
        cyc();
        rst_n = 0;
        #1;
        check("t5_r_valid_async", r_valid, 0);
        check("t5_ar_ready_async", ar_ready, 0);
        r_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc();
        r_ready = 1;
        do_ar(6'h22, 64'h1A00_0000, 8'd3);
        collect(4, 0, "t5");
        check("t5_r_id", last_r_id, 6'h22);

`ifdef AXI_DECERR_CAPTURE_EN
        fault_clr = 1; cyc(); fault_clr = 0;
        check("t6_cleared", fault_valid, 0);
        do_write(6'h03, 64'h6000_0000);
        r_ready = 1;
        do_ar(6'h04, 64'h7000_0000, 8'd0);
        collect(1, 0, "t6_r");
        check("t6_fault_valid", fault_valid, 1);
        check("t6_fault_addr", fault_addr, 64'h6000_0000);
        fault_clr = 1; cyc(); fault_clr = 0;
        check("t6_clr", fault_valid, 0);
        r_ready = 1;
        do_ar(6'h05, 64'h8000_0000, 8'd0);
        collect(1, 0, "t6_r2");
        check("t6_recapture", fault_addr, 64'h8000_0000);
`else
        check("t6_fault_tied", fault_valid, 0);
        check("t6_fault_addr_tied", fault_addr, 64'h0);
`endif
        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
